f_register_file_param: RTL and testbench
========================================

F_REGISTER_FILE_PARAM -- requirements
Module: f_register_file_param

Interface
- REQ-001 SHALL have parameter DATA_W, 32, floating-point register width in bits (legal 8..64).
- REQ-002 SHALL have parameter NREGS, 32, number of FP registers (power of two, 2..32); address width AW = log2(NREGS).
- REQ-003 SHALL have parameter NUM_RD, 2, number of independent read ports (1..3).
- REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
- REQ-005 SHALL have port nrst  in  1  synchronous, active-low reset.
- REQ-006 SHALL have ports rs_addr  in  NUM_RD*AW  read addresses, and rs_data  out  NUM_RD*DATA_W  read data; port i occupies slice i.
- REQ-007 SHALL have ports wen  in  1, rd_addr  in  AW, w_data  in  DATA_W  writeback port.
- REQ-008 SHALL have ports issue_valid  in  1 and issue_rd  in  AW  mark a destination pending.
- REQ-009 SHALL have port busy  out  NREGS  per-register pending scoreboard.
- REQ-010 SHALL have ports flags_valid  in  1 and flags_in  in  5  exception flags {NV,DZ,OF,UF,NX}.
- REQ-011 SHALL have ports csr_wen  in  1, csr_sel  in  2 (0 fflags, 1 frm, 2 fcsr, 3 reserved), csr_wdata  in  8.
- REQ-012 SHALL have ports csr_rdata  out  8, frm_out  out  3, fflags_out  out  5.

Function
- REQ-013 Reads SHALL be combinational from the register array; no read latency.
- REQ-014 When wen=1, register[rd_addr] SHALL take w_data at the next edge.
- REQ-015 flags_valid=1 SHALL OR flags_in into sticky fflags at the next edge; bits clear only via CSR write or reset.
- REQ-016 csr_wen: sel 0 writes fflags=csr_wdata[4:0]; sel 1 writes frm=csr_wdata[2:0]; sel 2 writes frm=[7:5], fflags=[4:0]; sel 3 SHALL be ignored.
- REQ-017 csr_wen writing fflags in the same cycle as flags_valid: CSR value SHALL win, flags_in discarded for that cycle.
- REQ-018 csr_rdata SHALL be combinational: sel 0 {3'b0,fflags}, sel 1 {5'b0,frm}, sel 2 {frm,fflags}, sel 3 8'h00.
- REQ-019 frm values 5,6 SHALL be stored and output unchanged (legality checked downstream).
- REQ-020 issue_valid SHALL set busy[issue_rd]; wen SHALL clear busy[rd_addr]; both same register same cycle: busy SHALL remain set.
- REQ-021 wen to a register whose busy bit is clear SHALL still write data.
- REQ-022 No hardwired-zero register; register 0 is writable.

Reset
- REQ-023 nrst=0 at an edge SHALL clear all registers, frm, fflags and busy to 0; wen, issue_valid, flags_valid, csr_wen SHALL be ignored that cycle.
- REQ-024 Reset asserted mid-operation SHALL discard any in-flight write; outputs reflect zeroed state from the following cycle.

Configuration
- REQ-025 Macro F_RF_BYPASS_EN defined: a read whose address equals rd_addr with wen=1 SHALL return w_data in the same cycle; csr_rdata SHALL likewise reflect a same-cycle csr_wen value.
- REQ-026 Macro undefined: reads SHALL return the stored (pre-write) value; write visible the next cycle.

Structure
- REQ-027 Package f_rf_pkg SHALL hold fflags_t (packed struct NV,DZ,OF,UF,NX), frm_t enum (RNE=0,RTZ=1,RDN=2,RUP=3,RMM=4,DYN=7), and csr_sel encodings.
- REQ-028 The fcsr logic (frm, fflags, csr read/write, flag accumulation) SHALL be a sub-module f_fcsr_unit; array and scoreboard stay in the top.

Verification
- REQ-029 Reset, then read all registers and csr sel 2 -> all zero, busy=0.
- REQ-030 DATA_W=32: write reg 5 = 32'h3F800000, read on port 0 and port 1 next cycle -> both 32'h3F800000; same-cycle read -> 32'h3F800000 with F_RF_BYPASS_EN, 0 without.
- REQ-031 flags_valid with 5'b00001 then 5'b10000 -> fflags_out=5'b10001; csr_wen sel 0 data 0 plus flags_valid 5'b00100 same cycle -> fflags_out=0.
- REQ-032 csr_wen sel 2 data 8'hE3 -> frm_out=3'b111, fflags_out=5'b00011, csr_rdata sel 1 = 8'h07.
- REQ-033 issue reg 9, then wen reg 9 with issue reg 9 same cycle -> busy[9]=1; following wen alone -> busy[9]=0.
- REQ-034 Assert nrst during wen to reg 3 = 32'hDEADBEEF -> reg 3 reads 0 afterwards.

Source files
------------

// File: rtl/f_rf_pkg.sv
// Shared types for the FP register file: exception flag layout, rounding modes
// and fcsr sub-register select encodings.
package f_rf_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [2:0] {
        FRM_RNE = 3'd0,
        FRM_RTZ = 3'd1,
        FRM_RDN = 3'd2,
        FRM_RUP = 3'd3,
        FRM_RMM = 3'd4,
        FRM_DYN = 3'd7
    } frm_t;

    typedef enum logic [1:0] {
        CSR_FFLAGS = 2'd0,
        CSR_FRM    = 2'd1,
        CSR_FCSR   = 2'd2,
        CSR_RSVD   = 2'd3
    } csr_sel_t;

    function automatic logic [7:0] fcsr_pack(input logic [2:0] frm, input fflags_t ff);
        return {frm, ff};
    endfunction

endpackage

// File: rtl/f_register_file_param_fcsr.sv
// fcsr unit: rounding mode, sticky exception flags and CSR read/write port.
// Optional macro F_RF_BYPASS_EN makes csr_rdata show a same-cycle CSR write.
module f_fcsr_unit
    import f_rf_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       flags_valid,
    input  logic [4:0] flags_in,
    input  logic       csr_wen,
    input  logic [1:0] csr_sel,
    input  logic [7:0] csr_wdata,
    output logic [7:0] csr_rdata,
    output logic [2:0] frm_out,
    output logic [4:0] fflags_out
);

    fflags_t    r_fflags;
    logic [2:0] r_frm;

    logic       w_wr_fflags;
    logic       w_wr_frm;
    fflags_t    w_new_fflags;
    logic [2:0] w_new_frm;
    fflags_t    w_view_fflags;
    logic [2:0] w_view_frm;

    assign w_wr_fflags  = csr_wen && ((csr_sel == CSR_FFLAGS) || (csr_sel == CSR_FCSR));
    assign w_wr_frm     = csr_wen && ((csr_sel == CSR_FRM) || (csr_sel == CSR_FCSR));
    assign w_new_fflags = fflags_t'(csr_wdata[4:0]);
    assign w_new_frm    = (csr_sel == CSR_FCSR) ? csr_wdata[7:5] : csr_wdata[2:0];

    // State update; a CSR write to fflags overrides same-cycle flag accumulation.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_fflags <= fflags_t'(5'd0);
            r_frm    <= 3'd0;
        end else begin
            if (w_wr_fflags) begin
                r_fflags <= w_new_fflags;
            end else if (flags_valid) begin
                r_fflags <= fflags_t'(r_fflags | flags_in);
            end else begin
                r_fflags <= r_fflags;
            end
            if (w_wr_frm) begin
                r_frm <= w_new_frm;
            end else begin
                r_frm <= r_frm;
            end
        end
    end

`ifdef F_RF_BYPASS_EN
    assign w_view_fflags = w_wr_fflags ? w_new_fflags : r_fflags;
    assign w_view_frm    = w_wr_frm ? w_new_frm : r_frm;
`else
    assign w_view_fflags = r_fflags;
    assign w_view_frm    = r_frm;
`endif

    // CSR read mux; reserved select reads as zero.
    always_comb begin
        csr_rdata = 8'h00;
        case (csr_sel)
            CSR_FFLAGS: csr_rdata = {3'b000, w_view_fflags};
            CSR_FRM:    csr_rdata = {5'b00000, w_view_frm};
            CSR_FCSR:   csr_rdata = fcsr_pack(w_view_frm, w_view_fflags);
            default:    csr_rdata = 8'h00;
        endcase
    end

    assign frm_out    = r_frm;
    assign fflags_out = r_fflags;

endmodule

// File: rtl/f_register_file_param.sv
// Parameterised FP register file with pending-write scoreboard and fcsr unit.
// Optional macro F_RF_BYPASS_EN forwards a same-cycle writeback to the read ports.
module f_register_file_param
    import f_rf_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*DATA_W-1:0] rs_data,
    input  logic                     wen,
    input  logic [AW-1:0]            rd_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic [NREGS-1:0]         busy,
    input  logic                     flags_valid,
    input  logic [4:0]               flags_in,
    input  logic                     csr_wen,
    input  logic [1:0]               csr_sel,
    input  logic [7:0]               csr_wdata,
    output logic [7:0]               csr_rdata,
    output logic [2:0]               frm_out,
    output logic [4:0]               fflags_out
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    // Register array; reset clears every entry and drops any in-flight write.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wen) begin
            r_regs[rd_addr] <= w_data;
        end else begin
            r_regs[rd_addr] <= r_regs[rd_addr];
        end
    end

    // Scoreboard: a new issue to the same register outranks the writeback clear.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (issue_valid && (issue_rd == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wen && (rd_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end else begin
                    r_busy[i] <= r_busy[i];
                end
            end
        end
    end

    assign busy = r_busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rs_addr[p*AW +: AW];
`ifdef F_RF_BYPASS_EN
        assign rs_data[p*DATA_W +: DATA_W] = (wen && (w_addr == rd_addr)) ? w_data : r_regs[w_addr];
`else
        assign rs_data[p*DATA_W +: DATA_W] = r_regs[w_addr];
`endif
    end

    f_fcsr_unit u_fcsr (
        .clk         (clk),
        .nrst        (nrst),
        .flags_valid (flags_valid),
        .flags_in    (flags_in),
        .csr_wen     (csr_wen),
        .csr_sel     (csr_sel),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .frm_out     (frm_out),
        .fflags_out  (fflags_out)
    );

endmodule

// File: tb/tb_f_register_file_param.sv
// Self-checking bench for f_register_file_param: directed scenarios plus
// randomized traffic compared against a behavioural array/scoreboard model.
module tb_f_register_file_param;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                     clk = 1'b0;
    logic                     nrst;
    logic [NUM_RD*AW-1:0]     rs_addr;
    logic [NUM_RD*DATA_W-1:0] rs_data;
    logic                     wen;
    logic [AW-1:0]            rd_addr;
    logic [DATA_W-1:0]        w_data;
    logic                     issue_valid;
    logic [AW-1:0]            issue_rd;
    logic [NREGS-1:0]         busy;
    logic                     flags_valid;
    logic [4:0]               flags_in;
    logic                     csr_wen;
    logic [1:0]               csr_sel;
    logic [7:0]               csr_wdata;
    logic [7:0]               csr_rdata;
    logic [2:0]               frm_out;
    logic [4:0]               fflags_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_busy;
    logic [2:0]        m_frm;
    logic [4:0]        m_fflags;

    f_register_file_param #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .wen         (wen),
        .rd_addr     (rd_addr),
        .w_data      (w_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .flags_valid (flags_valid),
        .flags_in    (flags_in),
        .csr_wen     (csr_wen),
        .csr_sel     (csr_sel),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .frm_out     (frm_out),
        .fflags_out  (fflags_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen         = 1'b0;
        issue_valid = 1'b0;
        flags_valid = 1'b0;
        csr_wen     = 1'b0;
    endtask

    task automatic set_rs(input int p, input int addr);
        rs_addr[p*AW +: AW] = AW'(addr);
    endtask

    // Architectural effect of one clock edge with the inputs currently applied.
    task automatic model_edge();
        if (!nrst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_busy   = '0;
            m_frm    = 3'd0;
            m_fflags = 5'd0;
        end else begin
            if (wen) begin
                m_regs[rd_addr] = w_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (issue_valid) m_busy[issue_rd] = 1'b1;
            if (csr_wen && csr_sel == 2'd0) begin
                m_fflags = csr_wdata[4:0];
            end else if (csr_wen && csr_sel == 2'd2) begin
                m_fflags = csr_wdata[4:0];
                m_frm    = csr_wdata[7:5];
            end else begin
                if (csr_wen && csr_sel == 2'd1) m_frm = csr_wdata[2:0];
                if (flags_valid) m_fflags = m_fflags | flags_in;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] e;
        logic [4:0]        ff;
        logic [2:0]        fr;
        logic [7:0]        ec;
        for (int p = 0; p < NUM_RD; p++) begin
            a = rs_addr[p*AW +: AW];
            e = m_regs[a];
`ifdef F_RF_BYPASS_EN
            if (wen && a == rd_addr) e = w_data;
`endif
            check($sformatf("%s_rd%0d", tag, p), 64'(rs_data[p*DATA_W +: DATA_W]), 64'(e));
        end
        check($sformatf("%s_busy", tag), 64'(busy), 64'(m_busy));
        check($sformatf("%s_frm", tag), 64'(frm_out), 64'(m_frm));
        check($sformatf("%s_fflags", tag), 64'(fflags_out), 64'(m_fflags));
        ff = m_fflags;
        fr = m_frm;
`ifdef F_RF_BYPASS_EN
        if (csr_wen && csr_sel == 2'd0) ff = csr_wdata[4:0];
        if (csr_wen && csr_sel == 2'd1) fr = csr_wdata[2:0];
        if (csr_wen && csr_sel == 2'd2) begin
            ff = csr_wdata[4:0];
            fr = csr_wdata[7:5];
        end
`endif
        case (csr_sel)
            2'd0:    ec = {3'b000, ff};
            2'd1:    ec = {5'b00000, fr};
            2'd2:    ec = {fr, ff};
            default: ec = 8'h00;
        endcase
        check($sformatf("%s_csr", tag), 64'(csr_rdata), 64'(ec));
    endtask

    initial begin
        logic [DATA_W-1:0] same_exp;
        nrst      = 1'b0;
        idle();
        rs_addr   = '0;
        rd_addr   = '0;
        w_data    = '0;
        issue_rd  = '0;
        flags_in  = 5'd0;
        csr_sel   = 2'd0;
        csr_wdata = 8'h00;
        cycle();
        cycle();
        nrst = 1'b1;
        #1;

        // Reset state: every register, fcsr and scoreboard zero.
        for (int a = 0; a < NREGS; a++) begin
            set_rs(0, a);
            set_rs(1, NREGS - 1 - a);
            #1;
            check($sformatf("rst_reg%0d_p0", a), 64'(rs_data[DATA_W-1:0]), 64'd0);
            check($sformatf("rst_reg%0d_p1", NREGS - 1 - a), 64'(rs_data[2*DATA_W-1:DATA_W]), 64'd0);
        end
        csr_sel = 2'd2;
        #1;
        check("rst_fcsr", 64'(csr_rdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Write reg 5 and read it on both ports, same cycle and next cycle.
        wen = 1'b1; rd_addr = AW'(5); w_data = 32'h3F800000;
        set_rs(0, 5); set_rs(1, 5);
        #1;
`ifdef F_RF_BYPASS_EN
        same_exp = 32'h3F800000;
`else
        same_exp = 32'h00000000;
`endif
        check("wr5_same_p0", 64'(rs_data[DATA_W-1:0]), 64'(same_exp));
        check("wr5_same_p1", 64'(rs_data[2*DATA_W-1:DATA_W]), 64'(same_exp));
        cycle();
        idle();
        #1;
        check("wr5_next_p0", 64'(rs_data[DATA_W-1:0]), 64'h3F800000);
        check("wr5_next_p1", 64'(rs_data[2*DATA_W-1:DATA_W]), 64'h3F800000);

        // Sticky flag accumulation, then CSR clear beating a same-cycle flag.
        flags_valid = 1'b1; flags_in = 5'b00001;
        cycle();
        flags_in = 5'b10000;
        cycle();
        idle();
        #1;
        check("flags_sticky", 64'(fflags_out), 64'h11);
        csr_wen = 1'b1; csr_sel = 2'd0; csr_wdata = 8'h00;
        flags_valid = 1'b1; flags_in = 5'b00100;
        cycle();
        idle();
        #1;
        check("flags_csr_wins", 64'(fflags_out), 64'h00);

        // Full fcsr write with reserved-range rounding mode.
        csr_wen = 1'b1; csr_sel = 2'd2; csr_wdata = 8'hE3;
        cycle();
        idle();
        csr_sel = 2'd1;
        #1;
        check("fcsr_frm", 64'(frm_out), 64'h7);
        check("fcsr_fflags", 64'(fflags_out), 64'h03);
        check("fcsr_rd_frm", 64'(csr_rdata), 64'h07);
        csr_wen = 1'b1; csr_sel = 2'd1; csr_wdata = 8'h05;
        cycle();
        idle();
        #1;
        check("frm_5_kept", 64'(frm_out), 64'h5);
        csr_wen = 1'b1; csr_sel = 2'd3; csr_wdata = 8'hFF;
        cycle();
        idle();
        #1;
        check("rsvd_ignored_frm", 64'(frm_out), 64'h5);
        check("rsvd_reads_zero", 64'(csr_rdata), 64'h00);

        // Scoreboard: issue wins over same-cycle writeback, later writeback clears.
        issue_valid = 1'b1; issue_rd = AW'(9);
        cycle();
        wen = 1'b1; rd_addr = AW'(9); w_data = 32'h12345678;
        cycle();
        idle();
        #1;
        check("busy9_held", 64'(busy[9]), 64'd1);
        wen = 1'b1; rd_addr = AW'(9); w_data = 32'h0BADF00D;
        cycle();
        idle();
        set_rs(0, 9);
        #1;
        check("busy9_clear", 64'(busy[9]), 64'd0);
        check("reg9_data", 64'(rs_data[DATA_W-1:0]), 64'h0BADF00D);
        check_outputs("dir");

        // Reset during a write discards it.
        wen = 1'b1; rd_addr = AW'(3); w_data = 32'h11111111;
        cycle();
        nrst = 1'b0; w_data = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_rd = AW'(4);
        cycle();
        nrst = 1'b1;
        idle();
        set_rs(0, 3); set_rs(1, 9);
        #1;
        check("rst_drop_reg3", 64'(rs_data[DATA_W-1:0]), 64'd0);
        check("rst_reg9", 64'(rs_data[2*DATA_W-1:DATA_W]), 64'd0);
        check("rst_busy_mid", 64'(busy), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            nrst        = ($urandom_range(0, 39) != 0);
            wen         = 1'($urandom);
            rd_addr     = AW'($urandom);
            w_data      = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom);
            flags_valid = ($urandom_range(0, 2) == 0);
            flags_in    = 5'($urandom);
            csr_wen     = ($urandom_range(0, 4) == 0);
            csr_sel     = 2'($urandom);
            csr_wdata   = 8'($urandom);
            rs_addr     = (NUM_RD*AW)'($urandom);
            if ($urandom_range(0, 2) == 0) set_rs(0, int'(rd_addr));
            #1;
            check_outputs($sformatf("rand%0d", n));
            cycle();
        end
        idle();
        nrst = 1'b1;
        #1;
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
